// File: rtl/sum_operator_multi.sv
// sum_operator_multi: multi-order discrete integrator.
// Each accepted sample d is run back through a cascade of max_order accumulators.
// A single shared adder is stepped one stage per clock by a two-state FSM.
// After the sequence, out[0] holds the reconstructed signal and out[k] holds the k-th difference.
// Optional build macro SUM_OP_SAT_EN: every add saturates instead of wrapping.
// It also adds a sticky sat output.
//
// Handshake: en and load are single-cycle strobes sampled on the rising clock edge.
// en is accepted only in IDLE with load low; otherwise it is dropped and overrun is set.
// busy is high from the accepting edge until the final stage is written.
// valid pulses for exactly one cycle when out[] is self-consistent again.
module sum_operator_multi #(
  parameter int max_order = 3,
  parameter int WIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] d,
  input  logic                    load,
  input  logic [2:0]              load_sel,
  input  logic signed [WIDTH-1:0] load_val,
  output logic signed [WIDTH-1:0] out [max_order-1:0],
  output logic                    valid,
  output logic                    busy,
  output logic                    overrun
`ifdef SUM_OP_SAT_EN
  ,
  output logic                    sat
`endif
);

  localparam int KW = (max_order > 1) ? $clog2(max_order) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(max_order - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                  state_q;
  logic [KW-1:0]           k_q;
  logic signed [WIDTH-1:0] d_q;
  logic signed [WIDTH-1:0] acc_q [max_order-1:0];
  logic                    valid_q;
  logic                    busy_q;
  logic                    overrun_q;

  // chain[k+1] is the input of stage k; the top stage is fed by the held sample.
  logic signed [WIDTH-1:0] chain [max_order:0];
  logic signed [WIDTH-1:0] add_a;
  logic signed [WIDTH-1:0] add_b;
  logic signed [WIDTH-1:0] add_res;

  // Build the cascade view: accumulators below, held sample on top.
  always_comb begin
    for (int i = 0; i < max_order; i++) begin
      chain[i] = acc_q[i];
    end
    chain[max_order] = d_q;
  end

  // Route the active stage and its already-updated upstream value into the shared adder.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < max_order; i++) begin
      if (k_q == KW'(i)) begin
        add_a = chain[i];
        add_b = chain[i+1];
      end
    end
  end

`ifdef SUM_OP_SAT_EN
  logic                    sat_q;
  logic signed [WIDTH:0]   add_wide;
  logic                    add_ovf;

  assign add_wide = {add_a[WIDTH-1], add_a} + {add_b[WIDTH-1], add_b};
  assign add_ovf  = add_wide[WIDTH] ^ add_wide[WIDTH-1];

  // Clamp the shared adder result to the signed range on overflow.
  always_comb begin
    add_res = add_wide[WIDTH-1:0];
    if (add_ovf) begin
      add_res = add_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign sat = sat_q;
`else
  // Plain two's-complement wrap; exact inverse of a wrapping difference stage.
  assign add_res = add_a + add_b;
`endif

  // Control FSM, stage counter, accumulators and all status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < max_order; i++) begin
        acc_q[i] <= '0;
      end
      d_q       <= '0;
      k_q       <= '0;
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SUM_OP_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            // Out-of-range indices match no stage and are silently ignored.
            for (int i = 0; i < max_order; i++) begin
              if (load_sel == 3'(i)) begin
                acc_q[i] <= load_val;
              end
            end
            if (en) begin
              overrun_q <= 1'b1;
            end
          end else if (en) begin
            d_q     <= d;
            k_q     <= K_LAST;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < max_order; i++) begin
            if (k_q == KW'(i)) begin
              acc_q[i] <= add_res;
            end
          end
`ifdef SUM_OP_SAT_EN
          if (add_ovf) begin
            sat_q <= 1'b1;
          end
`endif
          if (en || load) begin
            overrun_q <= 1'b1;
          end
          if (k_q == '0) begin
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out     = acc_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_sum_operator_multi.sv
// Testbench for sum_operator_multi: directed scenarios plus randomized traffic.
// Expected results come from an integer-arithmetic reference model.
module tb_sum_operator_multi;

  localparam int MO   = 3;
  localparam int W    = 16;
  localparam int VW   = MO * W;
  localparam int MAXV = (2 ** (W - 1)) - 1;
  localparam int MINV = -(2 ** (W - 1));

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (max_order = 3) ----------------
  logic                en = 1'b0;
  logic                load = 1'b0;
  logic signed [W-1:0] d = '0;
  logic signed [W-1:0] load_val = '0;
  logic [2:0]          load_sel = '0;
  logic signed [W-1:0] out [MO-1:0];
  logic                valid;
  logic                busy;
  logic                overrun;

  // ---------------- DUT (max_order = 1) ----------------
  logic                en1 = 1'b0;
  logic                load1 = 1'b0;
  logic signed [W-1:0] d1 = '0;
  logic signed [W-1:0] load_val1 = '0;
  logic [2:0]          load_sel1 = '0;
  logic signed [W-1:0] out1 [0:0];
  logic                valid1;
  logic                busy1;
  logic                overrun1;

`ifdef SUM_OP_SAT_EN
  logic sat;
  logic sat1;
  bit   m_sat = 1'b0;
`endif

  sum_operator_multi #(.max_order(MO), .WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .en(en), .d(d),
    .load(load), .load_sel(load_sel), .load_val(load_val),
    .out(out), .valid(valid), .busy(busy), .overrun(overrun)
`ifdef SUM_OP_SAT_EN
    , .sat(sat)
`endif
  );

  sum_operator_multi #(.max_order(1), .WIDTH(W)) u_dut1 (
    .clk(clk), .reset(reset), .en(en1), .d(d1),
    .load(load1), .load_sel(load_sel1), .load_val(load_val1),
    .out(out1), .valid(valid1), .busy(busy1), .overrun(overrun1)
`ifdef SUM_OP_SAT_EN
    , .sat(sat1)
`endif
  );

  // ---------------- reference model ----------------
  int m_acc [MO];
  bit m_ovr   = 1'b0;
  int m_start = -100;  // issue cycle of the sample in flight
  int m_free  = 0;     // first issue cycle at which a new strobe is accepted

  logic [VW-1:0] exp_q[$];
  int            cyc_q[$];

  int checks = 0;
  int errors = 0;

  function automatic int acc_add(input int a, input int b);
    int s;
    s = a + b;
`ifdef SUM_OP_SAT_EN
    if (s > MAXV) begin
      s = MAXV;
      m_sat = 1'b1;
    end else if (s < MINV) begin
      s = MINV;
      m_sat = 1'b1;
    end
`else
    if (s > MAXV) s = s - (2 ** W);
    else if (s < MINV) s = s + (2 ** W);
`endif
    return s;
  endfunction

  // Integrate one sample: each integrator absorbs its input, and its new value feeds the one below.
  task automatic model_sample(input int dv);
    int feed;
    feed = dv;
    for (int k = MO - 1; k >= 0; k--) begin
      m_acc[k] = acc_add(m_acc[k], feed);
      feed = m_acc[k];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < MO; k++) m_acc[k] = 0;
    m_ovr   = 1'b0;
    m_start = -100;
    m_free  = 0;
`ifdef SUM_OP_SAT_EN
    m_sat = 1'b0;
`endif
  endtask

  function automatic logic [VW-1:0] pack_model();
    logic [VW-1:0] v;
    int t;
    for (int k = 0; k < MO; k++) begin
      t = m_acc[k];
      v[k*W +: W] = t[W-1:0];
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] pack_dut();
    logic [VW-1:0] v;
    for (int k = 0; k < MO; k++) v[k*W +: W] = out[k];
    return v;
  endfunction

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs at a falling edge and update the model with what the DUT should do.
  task automatic issue(input bit do_en, input int dv, input bit do_load, input int sel, input int val);
    bit idle;
    @(negedge clk);
    en       = do_en;
    d        = W'(dv);
    load     = do_load;
    load_sel = 3'(sel);
    load_val = W'(val);
    idle = (cyc >= m_free);
    if (do_load) begin
      if (idle) begin
        if (sel < MO) m_acc[sel] = val;
        if (do_en) m_ovr = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (do_en) begin
      if (idle) begin
        model_sample(dv);
        exp_q.push_back(pack_model());
        cyc_q.push_back(cyc + MO + 1);
        m_start = cyc;
        m_free  = cyc + MO + 1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic release_in();
    issue(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic strobe(input int dv);
    issue(1'b1, dv, 1'b0, 0, 0);
    release_in();
  endtask

  task automatic seed(input int sel, input int val);
    issue(1'b0, 0, 1'b1, sel, val);
    release_in();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    int guard;
    guard = 0;
    while (cyc < m_free && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check_val("settled_out", pack_dut(), pack_model());
    check_val("settled_busy", 64'(busy), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [VW-1:0] e;
    int            c;
    if (reset) begin
      check_val("busy", 64'(busy), 64'((cyc > m_start) && (cyc < m_free)));
      if (valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL valid_unexpected: got valid=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check_val("valid_data", pack_dut(), e);
          check_val("valid_latency", 64'(cyc), 64'(c));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of run, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int recon_d [5] = '{1, 1, -2, -15, 29};

  initial begin
    int n;
    int got_cyc;
    int op;
    model_reset();

    // Reset state.
    #1 reset = 1'b0;
    #12;
    check_val("reset_out", pack_dut(), '0);
    check_val("reset_valid", 64'(valid), 64'd0);
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_overrun", 64'(overrun), 64'd0);
    @(negedge clk) reset = 1'b1;

    // Reconstruction: one strobe every 10 clocks.
    foreach (recon_d[i]) begin
      strobe(recon_d[i]);
      idle_cycles(8);
    end
    settle();

    // Seeding the accumulators, then zero-difference samples.
    seed(0, 100);
    seed(1, 5);
    seed(2, 0);
    idle_cycles(1);
    check_val("seed_out", pack_dut(), pack_model());
    repeat (3) begin
      strobe(0);
      settle();
    end

    // Async reset between E+1 and E+2: the sample in flight is discarded.
    @(negedge clk);
    m_start = cyc;
    m_free  = cyc + MO + 1;
    en = 1'b1;
    d  = W'(5);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_val("midrun_reset_out", pack_dut(), '0);
    check_val("midrun_reset_busy", 64'(busy), 64'd0);
    check_val("midrun_reset_valid", 64'(valid), 64'd0);
    @(negedge clk) reset = 1'b1;
    idle_cycles(4);
    strobe(7);
    settle();
    check_val("no_overrun_yet", 64'(overrun), 64'd0);

    // Out-of-range load index is ignored without a flag.
    seed(5, 1234);
    idle_cycles(1);
    check_val("load_sel_oob_out", pack_dut(), pack_model());
    check_val("load_sel_oob_ovr", 64'(overrun), 64'd0);

    // en together with load in IDLE: load wins, en dropped.
    issue(1'b1, 4, 1'b1, 1, -20);
    release_in();
    idle_cycles(4);
    check_val("en_load_out", pack_dut(), pack_model());
    check_val("en_load_ovr", 64'(overrun), 64'(m_ovr));

    // Back-to-back strobes at E and E+1: the second is dropped.
    pulse_reset();
    issue(1'b1, 3, 1'b0, 0, 0);
    issue(1'b1, 9, 1'b0, 0, 0);
    release_in();
    settle();
    check_val("pair_ovr", 64'(overrun), 64'd1);

    // Wrap/saturate at the top of the range through the cascade.
    seed(0, MAXV);
    seed(1, 0);
    seed(2, 0);
    strobe(1);
    settle();

    // max_order = 1: one-cycle RUN, wrap or clamp at the positive limit.
    @(negedge clk);
    load1 = 1'b1;
    load_sel1 = 3'd0;
    load_val1 = W'(MAXV);
    @(negedge clk);
    load1 = 1'b0;
    en1 = 1'b1;
    d1  = W'(1);
    n = cyc;
    @(negedge clk);
    en1 = 1'b0;
    got_cyc = -1;
    for (int i = 0; i < 6; i++) begin
      if (valid1) begin
        got_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check_val("mo1_latency", 64'(got_cyc), 64'(n + 2));
`ifdef SUM_OP_SAT_EN
    check_val("mo1_out", 64'(out1[0]), 64'(W'(MAXV)));
    check_val("mo1_sat", 64'(sat1), 64'd1);
`else
    check_val("mo1_out", 64'(out1[0]), 64'(W'(MINV)));
`endif
    check_val("mo1_busy", 64'(busy1), 64'd0);

    // Randomized traffic: strobes, loads, collisions and gaps.
    pulse_reset();
    repeat (400) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        strobe(int'($urandom_range(0, 65535)) - 32768);
      end else if (op <= 7) begin
        seed(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)) - 32768);
      end else if (op == 8) begin
        issue(1'b1, int'($urandom_range(0, 255)), 1'b1, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 65535)) - 32768);
        release_in();
      end else begin
        idle_cycles(int'($urandom_range(0, 4)));
      end
    end
    settle();
    idle_cycles(3);

    check_val("pending_expected", 64'(exp_q.size()), 64'd0);
    check_val("final_overrun", 64'(overrun), 64'(m_ovr));
`ifdef SUM_OP_SAT_EN
    check_val("final_sat", 64'(sat), 64'(m_sat));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
